up_counter3: RTL and testbench



---
 rtl/up_counter3_if.sv | 54 +++++
 rtl/up_counter3.sv | 24 ++
 tb/tb_up_counter3.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/up_counter3_if.sv
// Verification-side view of the counter: clocking blocks, modports,
// protocol assertions and a reset helper shared by driver and monitor.
interface count_intf (input logic clk);

    logic       rst;
    logic [2:0] count;

    // Checks stay quiet until the first reset edge has defined the counter.
    bit r_armed;

    clocking drv_cb @(posedge clk);
        default input #1step output #1;
        output rst;
        input  count;
    endclocking

    clocking mon_cb @(posedge clk);
        default input #1step;
        input rst;
        input count;
    endclocking

    modport DRIVER  (clocking drv_cb, input clk);
    modport MONITOR (clocking mon_cb, input clk);
    modport DUT     (input clk, input rst, output count);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_armed <= 1'b1;
        end
    end

    task automatic reset(input int n);
        drv_cb.rst <= 1'b0;
        repeat (n) @(drv_cb);
        drv_cb.rst <= 1'b1;
    endtask

    a_reset_clears : assert property (@(posedge clk) disable iff (!r_armed)
        !rst |=> count == 3'd0);

    a_increment : assert property (@(posedge clk) disable iff (!r_armed)
        rst && $past(rst) |-> count == 3'($past(count) + 3'd1));

    a_known : assert property (@(posedge clk) disable iff (!r_armed)
        !$isunknown(count));

    c_wrap : cover property (@(posedge clk) disable iff (!r_armed)
        count == 3'd7 ##1 count == 3'd0);

    c_reset_nonzero : cover property (@(posedge clk) disable iff (!r_armed)
        !rst && count != 3'd0);

endinterface

// File: rtl/up_counter3.sv
// Free-running WIDTH-bit up counter with synchronous active-low reset;
// wraps modulo 2^WIDTH with no flag and no idle cycle.
module up_counter3 #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Reset wins over increment; truncation provides the wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_up_counter3.sv
// Directed bench for up_counter3: reset, counting, wrap, mid-run reset,
// between-edge reset glitch and a long free run against a simple model.
module tb_up_counter3;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    count_intf intf (.clk(clk));

    up_counter3 #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst   (intf.rst),
        .count (intf.count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        intf.rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (intf.count !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: got %0d expected 0", i, intf.count);
            end
        end
    endtask

    task automatic test_count_run();
        logic [2:0] exp_seq [10];
        exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        intf.rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (intf.count !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL count_run edge %0d: got %0d expected %0d", i, intf.count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) step();
        n_tests++;
        if (intf.count !== 3'd5) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got %0d expected 5", intf.count);
        end
        intf.rst = 1'b0;
        step();
        n_tests++;
        if (intf.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: got %0d expected 0", intf.count);
        end
        intf.rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_tests++;
            if (intf.count !== 3'(i)) begin
                n_fail++;
                $display("FAIL reset_mid_resume %0d: got %0d expected %0d", i, intf.count, i);
            end
        end
    endtask

    task automatic test_reset_at_7();
        repeat (4) step();
        n_tests++;
        if (intf.count !== 3'd7) begin
            n_fail++;
            $display("FAIL reset7_pre: got %0d expected 7", intf.count);
        end
        intf.rst = 1'b0;
        step();
        n_tests++;
        if (intf.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset7_clear: got %0d expected 0", intf.count);
        end
        intf.rst = 1'b1;
        step();
        n_tests++;
        if (intf.count !== 3'd1) begin
            n_fail++;
            $display("FAIL reset7_resume: got %0d expected 1", intf.count);
        end
    endtask

    task automatic test_glitch();
        intf.rst = 1'b0;
        #2;
        intf.rst = 1'b1;
        step();
        n_tests++;
        if (intf.count !== 3'd2) begin
            n_fail++;
            $display("FAIL glitch: got %0d expected 2", intf.count);
        end
    endtask

    task automatic test_free_run();
        logic [2:0] exp_cnt;
        int         wraps;
        intf.rst = 1'b0;
        step();
        intf.rst = 1'b1;
        exp_cnt  = 3'd0;
        wraps    = 0;
        n_tests++;
        if (intf.count !== exp_cnt) begin
            n_fail++;
            $display("FAIL free_run_reset: got %0d expected 0", intf.count);
        end
        for (int i = 0; i < 48; i++) begin
            step();
            if (exp_cnt == 3'd7) wraps++;
            exp_cnt = 3'(exp_cnt + 3'd1);
            n_tests++;
            if (intf.count !== exp_cnt) begin
                n_fail++;
                $display("FAIL free_run edge %0d: got %0d expected %0d", i, intf.count, exp_cnt);
            end
        end
        n_tests++;
        if (wraps != 6 || intf.count !== 3'd0) begin
            n_fail++;
            $display("FAIL free_run_wraps: got %0d wraps ending at %0d, expected 6 ending at 0",
                     wraps, intf.count);
        end
    endtask

    initial begin
        intf.rst = 1'b1;
        #2;
        test_reset();
        test_count_run();
        test_reset_mid();
        test_reset_at_7();
        test_glitch();
        test_free_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
